// File: rtl/input_stager_pkg.sv
// Shared configuration for the input stager: default geometry, FSM encodings
// and a width helper for the pixel index.
package input_stager_pkg;

    localparam int unsigned DEFAULT_BITLENGTH = 12;
`ifdef SPARSE
    localparam int unsigned DEFAULT_INPUT_DIM = 64;
`else
    localparam int unsigned DEFAULT_INPUT_DIM = 784;
`endif

    localparam int unsigned FRAME_COUNT_W = 16;

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Index width that still works for a one-pixel frame.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/input_stager.sv
// Collects a frame of pixel words into a packed buffer, presents it to the
// RBM Main stage until finish rises, then counts the frame and refills.
module input_stager
    import input_stager_pkg::*;
#(
    parameter int unsigned bitlength = DEFAULT_BITLENGTH,
    parameter int unsigned input_dim = DEFAULT_INPUT_DIM
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           pixel_valid,
    input  logic [bitlength-1:0]           pixel_data,
    input  logic                           pixel_last,
    output logic                           pixel_ready,
    output logic [input_dim*bitlength-1:0] InputDataPort,
    output logic                           data_valid,
    input  logic                           finish,
    output logic                           frame_error,
    output logic [FRAME_COUNT_W-1:0]       frame_count
);

    localparam int unsigned IDX_W = idx_width(input_dim);
    localparam int unsigned PORT_W = input_dim * bitlength;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(input_dim - 1);

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [PORT_W-1:0]        fill_q, fill_d;
    logic [PORT_W-1:0]        port_q, port_d;
    logic                     data_valid_q, data_valid_d;
    logic                     frame_error_q, frame_error_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
    logic                     pixel_ready_q, pixel_ready_d;
    logic                     finish_q;
    logic                     accept_s;
    logic                     finish_rise_s;

    assign accept_s      = pixel_valid && pixel_ready_q;
    assign finish_rise_s = finish && !finish_q;

    // Next-state logic; pixels land in a shadow buffer so an aborted frame never disturbs the presented one.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fill_d        = fill_q;
        port_d        = port_q;
        data_valid_d  = data_valid_q;
        frame_error_d = 1'b0;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    fill_d[idx_q*bitlength +: bitlength] = pixel_data;
                    if (idx_q == LAST_IDX) begin
                        port_d        = fill_d;
                        state_d       = ST_HOLD;
                        idx_d         = '0;
                        data_valid_d  = 1'b1;
                        frame_error_d = !pixel_last;
                    end else if (pixel_last) begin
                        idx_d         = '0;
                        frame_error_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_HOLD: begin
                if (finish_rise_s) begin
                    state_d       = ST_RELEASE;
                    data_valid_d  = 1'b0;
                    frame_count_d = frame_count_q + 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                state_d = ST_FILL;
            end
            default: begin
                state_d      = ST_FILL;
                idx_d        = '0;
                data_valid_d = 1'b0;
            end
        endcase
        pixel_ready_d = (state_d == ST_FILL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_FILL;
            idx_q         <= '0;
            fill_q        <= '0;
            port_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            frame_count_q <= '0;
            pixel_ready_q <= 1'b1;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fill_q        <= fill_d;
            port_q        <= port_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            frame_count_q <= frame_count_d;
            pixel_ready_q <= pixel_ready_d;
            finish_q      <= finish;
        end
    end

    assign pixel_ready   = pixel_ready_q;
    assign InputDataPort = port_q;
    assign data_valid    = data_valid_q;
    assign frame_error   = frame_error_q;
    assign frame_count   = frame_count_q;

endmodule
